// File: rtl/mulchan_rd_scheduler.sv
// Round-robin scheduler sharing one AXI read master among CH_NUM read channels.
// Define ARB_FIXED_PRIO_EN to select the lowest-index requester instead of round-robin.
module mulchan_rd_scheduler #(
    parameter int unsigned CH_NUM   = 4,
    parameter int unsigned CH_IDX_W = 2,
    parameter int unsigned ADDR_W   = 30,
    parameter int unsigned LEN_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CH_NUM-1:0]          ch_rd_req,
    input  logic [CH_NUM*ADDR_W-1:0]   ch_rd_addr,
    input  logic [CH_NUM*LEN_W-1:0]    ch_rd_len,
    output logic [CH_NUM-1:0]          ch_rd_grant,
    input  logic                       axi_rd_ready,
    input  logic                       axi_rd_done,
    output logic                       axi_rd_start,
    output logic [ADDR_W-1:0]          axi_rd_addr,
    output logic [LEN_W-1:0]           axi_rd_len,
    output logic [CH_IDX_W-1:0]        cur_chan,
    output logic                       arb_busy
);

    typedef enum logic [1:0] {StIdle, StStart, StBusy} state_e;

    state_e                state_q, state_d;
    logic [CH_NUM-1:0]     grant_q, grant_d;
    logic                  start_q, start_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [CH_IDX_W-1:0]   cur_q, cur_d;
    logic [CH_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  busy_q;

    logic [CH_IDX_W-1:0]   winner;
    logic                  win_valid;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (!win_valid && ch_rd_req[CH_IDX_W'(i)]) begin
                winner    = CH_IDX_W'(i);
                win_valid = 1'b1;
            end
        end
    end
`else
    logic [CH_IDX_W-1:0] cand;

    // Search starts at rr_ptr and wraps modulo CH_NUM, so non-power-of-two counts stay in range.
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            cand = CH_IDX_W'((32'(rr_ptr_q) + i) % CH_NUM);
            if (!win_valid && ch_rd_req[cand]) begin
                winner    = cand;
                win_valid = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        start_d  = 1'b0;
        addr_d   = addr_q;
        len_d    = len_q;
        cur_d    = cur_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d  = StStart;
                    grant_d  = {{(CH_NUM-1){1'b0}}, 1'b1} << winner;
                    cur_d    = winner;
                    addr_d   = ch_rd_addr[32'(winner)*ADDR_W +: ADDR_W];
                    len_d    = ch_rd_len[32'(winner)*LEN_W +: LEN_W];
                    rr_ptr_d = (winner == CH_IDX_W'(CH_NUM-1)) ? '0 : winner + 1'b1;
                end
            end
            StStart: begin
                if (axi_rd_ready) begin
                    state_d = StBusy;
                    start_d = 1'b1;
                end
            end
            StBusy: begin
                // Grant stays up through the done cycle; the channel samples grant && done.
                if (axi_rd_done) begin
                    state_d = StIdle;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            start_q  <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            cur_q    <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            start_q  <= start_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cur_q    <= cur_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= (state_d != StIdle);
        end
    end

    assign ch_rd_grant  = grant_q;
    assign axi_rd_start = start_q;
    assign axi_rd_addr  = addr_q;
    assign axi_rd_len   = len_q;
    assign cur_chan     = cur_q;
    assign arb_busy     = busy_q;

endmodule

// File: tb/tb_mulchan_rd_scheduler.sv
// Randomized scoreboard bench for mulchan_rd_scheduler (4 channels).
module tb_mulchan_rd_scheduler;

    localparam int CH = 4;
    localparam int AW = 30;
    localparam int LW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     ch_rd_req;
    logic [CH*AW-1:0]  ch_rd_addr;
    logic [CH*LW-1:0]  ch_rd_len;
    logic [CH-1:0]     ch_rd_grant;
    logic              axi_rd_ready;
    logic              axi_rd_done;
    logic              axi_rd_start;
    logic [AW-1:0]     axi_rd_addr;
    logic [LW-1:0]     axi_rd_len;
    logic [1:0]        cur_chan;
    logic              arb_busy;

    mulchan_rd_scheduler #(
        .CH_NUM   (CH),
        .CH_IDX_W (2),
        .ADDR_W   (AW),
        .LEN_W    (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_rd_req    (ch_rd_req),
        .ch_rd_addr   (ch_rd_addr),
        .ch_rd_len    (ch_rd_len),
        .ch_rd_grant  (ch_rd_grant),
        .axi_rd_ready (axi_rd_ready),
        .axi_rd_done  (axi_rd_done),
        .axi_rd_start (axi_rd_start),
        .axi_rd_addr  (axi_rd_addr),
        .axi_rd_len   (axi_rd_len),
        .cur_chan     (cur_chan),
        .arb_busy     (arb_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    ch;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } exp_t;

    exp_t          sb[$];
    int            vectors = 0;
    int            errors  = 0;
    int unsigned   rr_ptr_m = 0;
    bit            mon_en = 1'b0;
    logic [AW-1:0] a_m[CH];
    logic [LW-1:0] l_m[CH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_chans();
        for (int i = 0; i < CH; i++) begin
            a_m[i] = AW'($urandom);
            l_m[i] = LW'($urandom);
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < CH; i++) begin
            ch_rd_addr[i*AW +: AW] = a_m[i];
            ch_rd_len[i*LW +: LW]  = l_m[i];
        end
    endtask

    // Expected winner straight from the arbitration rule.
    function automatic int pick(input logic [CH-1:0] m, input int unsigned p);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < CH; i++) if (m[i]) return i;
`else
        for (int i = 0; i < CH; i++) if (m[(p + i) % CH]) return int'((p + i) % CH);
`endif
        return -1;
    endfunction

    // One arbitration: k cycles of ready stall, d extra BUSY cycles, optional reset mid-burst.
    task automatic run_txn(input logic [CH-1:0] mask, input int k, input int d, input bit do_rst);
        int   w;
        exp_t e;
        ch_rd_req = mask;
        drive_bus();
        w = pick(mask, rr_ptr_m);
        e.ch = 2'(w);
        e.addr = a_m[w];
        e.len = l_m[w];
        sb.push_back(e);
        rr_ptr_m = (w + 1) % CH;
        axi_rd_ready = 1'($urandom);
        step();
        check("grant", ch_rd_grant, 1 << w);
        check("cur_chan", cur_chan, e.ch);
        check("addr_latch", axi_rd_addr, e.addr);
        check("len_latch", axi_rd_len, e.len);
        check("busy_start", arb_busy, 1);
        check("no_early_start", axi_rd_start, 0);
        ch_rd_req = CH'($urandom);
        new_chans();
        drive_bus();
        axi_rd_ready = (k == 0);
        for (int j = 0; j < k; j++) begin
            axi_rd_done = 1'($urandom);
            step();
            check("stall_grant", ch_rd_grant, 1 << w);
            check("stall_no_start", axi_rd_start, 0);
            if (j == k - 1) axi_rd_ready = 1'b1;
        end
        axi_rd_done = 1'b0;
        step();
        check("start_pulse", axi_rd_start, 1);
        axi_rd_ready = 1'($urandom);
        step();
        check("start_one_shot", axi_rd_start, 0);
        if (do_rst) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            rr_ptr_m = 0;
            check("rst_grant", ch_rd_grant, 0);
            check("rst_busy", arb_busy, 0);
            check("rst_addr", axi_rd_addr, 0);
            check("rst_cur", cur_chan, 0);
            ch_rd_req = '0;
            axi_rd_done = 1'b1;
            step();
            axi_rd_done = 1'b0;
            check("spurious_done_grant", ch_rd_grant, 0);
            check("spurious_done_start", axi_rd_start, 0);
            check("spurious_done_busy", arb_busy, 0);
            return;
        end
        for (int j = 0; j < d; j++) begin
            ch_rd_req = CH'($urandom);
            step();
            check("busy_hold_grant", ch_rd_grant, 1 << w);
            check("busy_hold_addr", axi_rd_addr, e.addr);
            check("busy_hold_len", axi_rd_len, e.len);
        end
        axi_rd_done = 1'b1;
        check("done_cycle_grant", ch_rd_grant, 1 << w);
        step();
        axi_rd_done = 1'b0;
        check("release_grant", ch_rd_grant, 0);
        check("release_busy", arb_busy, 0);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each start pulse.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("grant_onehot0", $countones(ch_rd_grant) <= 1, 1);
            check("busy_vs_grant", arb_busy, |ch_rd_grant);
            if (axi_rd_start) begin
                if (sb.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_grant", ch_rd_grant, 1 << e.ch);
                    check("sb_chan", cur_chan, e.ch);
                    check("sb_addr", axi_rd_addr, e.addr);
                    check("sb_len", axi_rd_len, e.len);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ch_rd_req = '1;
        axi_rd_ready = 1'b1;
        axi_rd_done = 1'b0;
        new_chans();
        drive_bus();
        step();
        step();
        check("reset_grant", ch_rd_grant, 0);
        check("reset_start", axi_rd_start, 0);
        check("reset_busy", arb_busy, 0);
        check("reset_addr", axi_rd_addr, 0);
        check("reset_len", axi_rd_len, 0);
        check("reset_cur", cur_chan, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            new_chans();
            run_txn(4'b1111, 0, 9, 1'b0);
        end
        new_chans();
        a_m[2] = 30'h0000100;
        l_m[2] = 8'd63;
        run_txn(4'b0100, 0, 17, 1'b0);
        new_chans();
        run_txn(4'b0010, 5, 3, 1'b0);
        new_chans();
        run_txn(4'b1001, 1, 2, 1'b0);
        new_chans();
        run_txn(4'b1001, 0, 2, 1'b0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                ch_rd_req = '0;
                step();
                check("idle_no_grant", ch_rd_grant, 0);
            end
            new_chans();
            run_txn(CH'($urandom_range(1, 15)), $urandom_range(0, 4), $urandom_range(0, 6),
                    $urandom_range(0, 11) == 0);
        end

        ch_rd_req = '0;
        step();
        step();
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
